// File: rtl/rr_arb_2x1.sv
// rr_arb_2x1: two-channel round-robin stream arbiter with registered output; ARB_GRANT_CNT_EN adds saturating grant counters
module rr_arb_2x1 #(
  parameter int BITS     = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITS-1:0]     in0,
  input  logic                in0_valid,
  output logic                in0_ready,
  input  logic [BITS-1:0]     in1,
  input  logic                in1_valid,
  output logic                in1_ready,
  output logic [BITS-1:0]     out,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef ARB_GRANT_CNT_EN
  output logic [CNT_BITS-1:0] cnt0,
  output logic [CNT_BITS-1:0] cnt1,
`endif
  output logic                sel
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          r_state, w_next_state;
  logic [BITS-1:0] r_out;
  logic            r_sel;
  logic            r_last_grant;
  logic            w_can_load;
  logic            w_grant;
  logic            w_take0;
  logic            w_take1;
  // grant picks the channel that did not win last time when both contend
  always_comb begin
    w_can_load   = (r_state == EMPTY) || out_ready;
    w_grant      = (in0_valid && in1_valid) ? !r_last_grant : in1_valid;
    w_take0      = w_can_load && !w_grant && in0_valid && !rst;
    w_take1      = w_can_load && w_grant && in1_valid && !rst;
    w_next_state = (w_take0 || w_take1) ? FULL : (w_can_load ? EMPTY : r_state);
  end
  // output register: load the granted word, otherwise hold data and sel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_out        <= '0;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_take0 || w_take1) begin
        r_out        <= w_take1 ? in1 : in0;
        r_sel        <= w_take1;
        r_last_grant <= w_take1;
      end
    end
  end
`ifdef ARB_GRANT_CNT_EN
  logic [CNT_BITS-1:0] r_cnt0, r_cnt1;
  // per-channel accepted-transfer counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      r_cnt0 <= (w_take0 && r_cnt0 != '1) ? r_cnt0 + 1'b1 : r_cnt0;
      r_cnt1 <= (w_take1 && r_cnt1 != '1) ? r_cnt1 + 1'b1 : r_cnt1;
    end
  end
  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif
  assign in0_ready = w_take0;
  assign in1_ready = w_take1;
  assign out       = r_out;
  assign out_valid = (r_state == FULL);
  assign sel       = r_sel;
endmodule

// File: tb/tb_rr_arb_2x1.sv
// tb_rr_arb_2x1: directed vector bench for rr_arb_2x1
module tb_rr_arb_2x1;
  logic       clk = 1'b0;
  logic       rst, in0_valid, in1_valid, out_ready;
  logic [3:0] in0, in1;
  logic       in0_ready, in1_ready, out_valid, sel;
  logic [3:0] out;
`ifdef ARB_GRANT_CNT_EN
  logic [1:0] cnt0, cnt1;
`endif
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rr_arb_2x1 #(.BITS(4), .CNT_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ARB_GRANT_CNT_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .sel(sel)
  );
  typedef struct {
    logic       rst;
    logic [3:0] d0;
    logic       v0;
    logic [3:0] d1;
    logic       v1;
    logic       ord;
    logic [1:0] rdy;
    logic [3:0] out;
    logic       ov;
    logic       sel;
  } vec_t;
  vec_t tv[22];
  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] d0, input logic v0, input logic [3:0] d1, input logic v1, input logic ord);
    rst = r; in0 = d0; in0_valid = v0; in1 = d1; in1_valid = v1; out_ready = ord;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //          rst d0    v0 d1    v1 ord rdy    out   ov sel
    tv[0]  = '{1'b1, 4'hA, 1, 4'h5, 1, 1, 2'b00, 4'h0, 0, 0};
    tv[1]  = '{1'b1, 4'hA, 1, 4'h5, 1, 1, 2'b00, 4'h0, 0, 0};
    tv[2]  = '{1'b0, 4'hA, 1, 4'h5, 1, 1, 2'b10, 4'hA, 1, 0};
    tv[3]  = '{1'b0, 4'hA, 1, 4'h5, 1, 1, 2'b01, 4'h5, 1, 1};
    tv[4]  = '{1'b0, 4'hA, 1, 4'h5, 1, 1, 2'b10, 4'hA, 1, 0};
    tv[5]  = '{1'b0, 4'hA, 1, 4'h5, 1, 1, 2'b01, 4'h5, 1, 1};
    tv[6]  = '{1'b0, 4'h0, 0, 4'h3, 1, 1, 2'b01, 4'h3, 1, 1};
    tv[7]  = '{1'b0, 4'h0, 0, 4'h7, 1, 1, 2'b01, 4'h7, 1, 1};
    tv[8]  = '{1'b0, 4'h0, 0, 4'h9, 1, 1, 2'b01, 4'h9, 1, 1};
    tv[9]  = '{1'b0, 4'hC, 1, 4'h0, 0, 1, 2'b10, 4'hC, 1, 0};
    tv[10] = '{1'b0, 4'h2, 1, 4'h6, 1, 0, 2'b00, 4'hC, 1, 0};
    tv[11] = '{1'b0, 4'h2, 1, 4'h6, 1, 0, 2'b00, 4'hC, 1, 0};
    tv[12] = '{1'b0, 4'h2, 1, 4'h6, 1, 0, 2'b00, 4'hC, 1, 0};
    tv[13] = '{1'b0, 4'h2, 1, 4'h6, 1, 1, 2'b01, 4'h6, 1, 1};
    tv[14] = '{1'b0, 4'h0, 0, 4'h0, 0, 1, 2'b00, 4'h6, 0, 1};
    tv[15] = '{1'b0, 4'h4, 1, 4'h0, 0, 1, 2'b10, 4'h4, 1, 0};
    tv[16] = '{1'b1, 4'h8, 1, 4'hE, 1, 0, 2'b00, 4'h0, 0, 0};
    tv[17] = '{1'b0, 4'hB, 1, 4'hD, 1, 1, 2'b10, 4'hB, 1, 0};
    tv[18] = '{1'b0, 4'h0, 0, 4'hD, 1, 0, 2'b00, 4'hB, 1, 0};
    tv[19] = '{1'b0, 4'h0, 0, 4'h0, 0, 0, 2'b00, 4'hB, 1, 0};
    tv[20] = '{1'b0, 4'h0, 0, 4'h0, 0, 1, 2'b00, 4'hB, 0, 0};
    tv[21] = '{1'b0, 4'h0, 0, 4'hD, 1, 0, 2'b01, 4'hD, 1, 1};
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].rst, tv[i].d0, tv[i].v0, tv[i].d1, tv[i].v1, tv[i].ord);
      #1;
      chk("ready", i, {6'b0, in0_ready, in1_ready}, {6'b0, tv[i].rdy});
      tick();
      chk("out/valid/sel", i, {out, 2'b0, out_valid, sel}, {tv[i].out, 2'b0, tv[i].ov, tv[i].sel});
    end
    drive(1'b1, 4'h0, 0, 4'h0, 0, 1);
    tick();
    drive(1'b0, 4'h1, 1, 4'hF, 1, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fair", i, {out, 2'b0, out_valid, sel}, {(i % 2 == 1) ? 4'hF : 4'h1, 2'b0, 1'b1, i % 2 == 1});
    end
`ifdef ARB_GRANT_CNT_EN
    drive(1'b1, 4'h0, 0, 4'h0, 0, 1);
    tick();
    chk("cnt_rst", 0, {4'b0, cnt0, cnt1}, 8'h00);
    drive(1'b0, 4'h3, 1, 4'h0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("cnt", i, {4'b0, cnt0, cnt1}, {4'b0, (i > 3) ? 2'd3 : 2'(i), 2'd0});
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb_2x1.md
Name: rr_arb_2x1

Overview:
- Two-channel round-robin stream arbiter with a registered output stage.
- Sits directly upstream of mux_2x1.
- Picks which of two valid/ready input streams is forwarded each cycle, registers the data, and exports the registered grant as sel so mux_2x1 and downstream logic see which source produced each word.

Parameters:
- BITS, 4, data width of in0, in1 and out.
- CNT_BITS, 8, width of per-channel grant counters (used only with ARB_GRANT_CNT_EN).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in0  input  BITS  channel 0 data.
- in0_valid  input  1  channel 0 data valid.
- in0_ready  output  1  channel 0 accepted this cycle when high with in0_valid.
- in1  input  BITS  channel 1 data.
- in1_valid  input  1  channel 1 data valid.
- in1_ready  output  1  channel 1 accepted this cycle when high with in1_valid.
- out  output  BITS  registered forwarded data.
- out_valid  output  1  out holds a word.
- out_ready  input  1  downstream accepts out this cycle.
- sel  output  1  registered source index of the current out word (0 = in0, 1 = in1).

Behaviour:
- Reset, sampled on the clk edge with rst = 1:
  - out = 0, out_valid = 0, sel = 0, internal last_grant = 1, so in0 wins the first contention.
- Reset mid-transfer:
  - The held word is dropped.
  - No ready is asserted in the reset cycle, since in0_ready = in1_ready = 0 while rst = 1.
- Output stage is one register, with two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
- can_load = !out_valid || out_ready. This is combinational, giving a full-throughput pipeline.
- grant is combinational:
  - both valid: grant = !last_grant.
  - only inX_valid: grant = X.
  - neither valid: no grant.
- inX_ready = can_load && grant == X && inX_valid && !rst.
  - At most one ready is high per cycle.
  - ready never depends on the other channel's data.
- Transfer on inX (inX_valid && inX_ready):
  - Next edge: out <= inX, sel <= X, out_valid <= 1, last_grant <= X.
- can_load with no input valid:
  - out_valid <= 0.
  - out and sel hold their last values.
- FULL and out_ready = 0:
  - out, sel and out_valid hold.
  - Both readys are 0.
  - last_grant is unchanged.
- Latency: input transfer to out_valid is 1 cycle.
- Throughput: 1 word/cycle when out_ready is held high.
- Fairness: with both inputs continuously valid and out_ready = 1, grants alternate 0,1,0,1…
- A single valid channel is granted every cycle. No idle bubble is inserted for the absent channel.
- Input rule: an input must keep valid and data stable until accepted. The arbiter does not check this, and behaviour is undefined if it is violated.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- Defined:
  - Adds outputs cnt0 and cnt1, each CNT_BITS wide.
  - Each counts accepted transfers on its channel and saturates at all-ones (no wrap).
  - Both are cleared by rst.
  - They update on the same edge as out.
- Undefined:
  - Ports and counter logic are absent.
  - Remaining behaviour is identical.

Test Plan:
1. Reset: rst = 1 for 2 cycles with both valids high -> in0_ready = in1_ready = 0, out_valid = 0, out = 0, sel = 0. After release, the first grant goes to in0.
2. Contention: in0 = 4'hA and in1 = 4'h5 both valid continuously, out_ready = 1 -> out sequence A,5,A,5 with sel 0,1,0,1, one word per cycle after 1-cycle latency.
3. Single source: only in1_valid with data 3,7,9, out_ready = 1 -> out 3,7,9 with sel = 1 each cycle. in0_ready stays 0.
4. Backpressure: out holds 4'hC (sel = 0), out_ready = 0 for 3 cycles with both inputs valid -> out = C, sel = 0 and out_valid = 1 hold, both readys are 0. When out_ready = 1 the next word is from in1.
5. Drain and reset mid-op: out_valid = 1, no inputs valid, out_ready = 1 -> out_valid goes 0 next cycle. Separately, assert rst while FULL -> out_valid = 0 and out = 0 next cycle.
6. With ARB_GRANT_CNT_EN and CNT_BITS = 2: 5 transfers on in0 -> cnt0 = 3 (saturated), cnt1 = 0.
